// File: rtl/calc_pkg.sv
// Shared definitions for the sequential divider: the controller state type
// and the fixed state encodings it uses.
package calc_pkg;

  // State encodings, kept as plain constants so older code can reuse them.
  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_RUN_ENC  = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    RUN  = ST_RUN_ENC,
    DONE = ST_DONE_ENC
  } div_state_e;

endpackage

// File: rtl/borrow_lookahead_sub.sv
// Combinational W-bit subtractor (a_i - b_i). Each bit's borrow-in is
// computed directly from the propagate/generate terms of the lower bits, so
// no borrow depends on another borrow signal.
module borrow_lookahead_sub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] difference,
  output logic         borrow_out
);

  // g: this bit creates a borrow; p: this bit passes an incoming borrow on.
  logic [W-1:0] g;
  logic [W-1:0] p;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      logic brw_in;

      assign g[gi] = ~a_i[gi] & b_i[gi];
      assign p[gi] = ~(a_i[gi] ^ b_i[gi]);

      // Borrow into this bit, flattened over all lower positions.
      always_comb begin
        brw_in = 1'b0;
        for (int j = 0; j < gi; j++) begin
          brw_in = g[j] | (p[j] & brw_in);
        end
      end

      assign difference[gi] = a_i[gi] ^ b_i[gi] ^ brw_in;
    end
  endgenerate

  // Borrow out of the top bit, same flattened form across the full width.
  always_comb begin
    borrow_out = 1'b0;
    for (int j = 0; j < W; j++) begin
      borrow_out = g[j] | (p[j] & borrow_out);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN: two's-complement operands, truncating
// division (operand magnitudes are divided, and sign fix-up is applied as the
// result is registered, so latency is unchanged).
module seq_divider
  import calc_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // dvd_q holds the dividend bits still to be consumed (MSB first) and
  // collects quotient bits from the bottom as they are produced.
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  remo_q, remo_d;
  logic          dbz_q, dbz_d;

  logic [N-1:0]  op_a, op_b;
  logic [N-1:0]  q_raw, r_raw;
  logic [N-1:0]  q_fin, r_fin;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Magnitudes of the incoming operands; -2^(N-1) maps onto 2^(N-1) unsigned.
  always_comb begin
    op_a = dividend[N-1] ? -dividend : dividend;
    op_b = divisor[N-1]  ? -divisor  : divisor;
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    q_fin = qneg_q ? -q_raw : q_raw;
    r_fin = rneg_q ? -r_raw : r_raw;
  end
`else
  // Unsigned build: operands and results pass straight through.
  always_comb begin
    op_a  = dividend;
    op_b  = divisor;
    q_fin = q_raw;
    r_fin = r_raw;
  end
`endif

  // One restoring step: shift in the next dividend bit and trial-subtract.
  logic [N:0] shifted;
  logic [N:0] trial_diff;
  logic       trial_borrow;
  logic       unused_diff_msb;

  assign shifted = {rem_q, dvd_q[N-1]};

  borrow_lookahead_sub #(
    .W (N + 1)
  ) u_sub (
    .a_i        (shifted),
    .b_i        ({1'b0, dvs_q}),
    .difference (trial_diff),
    .borrow_out (trial_borrow)
  );

  // A non-borrowing difference is always below the divisor, so its top bit is zero.
  assign unused_diff_msb = trial_diff[N];
  assign r_raw = trial_borrow ? shifted[N-1:0] : trial_diff[N-1:0];
  assign q_raw = {dvd_q[N-2:0], ~trial_borrow};

  // Controller and datapath next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d = op_b;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            // No iterations needed: report the fixed divide-by-zero result.
            state_d = DONE;
            quo_d   = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_LAST;
            dvd_d   = op_a;
            rem_d   = '0;
`ifdef DIV_SIGNED_EN
            qneg_d  = dividend[N-1] ^ divisor[N-1];
            rneg_d  = dividend[N-1];
`endif
          end
        end
      end
      RUN: begin
        rem_d = r_raw;
        dvd_d = q_raw;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = q_fin;
          remo_d  = r_fin;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset clears everything and aborts any division in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule
